// File: rtl/trap_ctrl_if.sv
// Bundle of EX-stage, CSR file and pipeline-control signals seen by trap_ctrl.
// master: the trap controller; slave: the pipeline/CSR file driving and consuming it.
interface trap_ctrl_if;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        exc_imis;
    logic        exc_ill;
    logic        exc_ebreak;
    logic        exc_ecall;
    logic        exc_lmis;
    logic        exc_smis;
    logic        is_mret;
    logic        irq_ext;
    logic        csr_op_valid;
    logic [2:0]  csr_funct3;
    logic [11:0] csr_addr_in;
    logic [31:0] csr_src;
    logic        csr_rs1_zero;
    logic [31:0] csr_rd_data;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        trap_enter;
    logic        trap_return;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        flush;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    modport master (
        input  ex_valid, ex_pc, exc_imis, exc_ill, exc_ebreak, exc_ecall, exc_lmis, exc_smis,
        input  is_mret, irq_ext, csr_op_valid, csr_funct3, csr_addr_in, csr_src, csr_rs1_zero,
        input  csr_rdata, mtvec, mepc,
        output csr_rd_data, csr_we, csr_addr, csr_wdata, trap_enter, trap_return, trap_pc,
        output trap_cause, flush, stall, redirect_valid, redirect_pc, busy
    );

    modport slave (
        output ex_valid, ex_pc, exc_imis, exc_ill, exc_ebreak, exc_ecall, exc_lmis, exc_smis,
        output is_mret, irq_ext, csr_op_valid, csr_funct3, csr_addr_in, csr_src, csr_rs1_zero,
        output csr_rdata, mtvec, mepc,
        input  csr_rd_data, csr_we, csr_addr, csr_wdata, trap_enter, trap_return, trap_pc,
        input  trap_cause, flush, stall, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap/CSR initiator: Zicsr RMW, exception/MRET/interrupt flush and redirect.
// Optional external interrupt handling is enabled by defining TRAP_CTRL_IRQ_EN.
module trap_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] IRQ_CAUSE    = 32'h8000000B
) (
    input logic         clk,
    input logic         rst,
    trap_ctrl_if.master bus
);
    typedef enum logic [1:0] {StIdle, StFlush, StRedirect} state_e;

    localparam logic [3:0] CntLast = 4'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        tgt_ret_q, tgt_ret_d;
    logic        ill_f3, exc_any, irq_take;
    logic [31:0] exc_cause;

    assign ill_f3  = bus.csr_op_valid && (bus.csr_funct3 == 3'b000 || bus.csr_funct3 == 3'b100);
    assign exc_any = bus.exc_imis | bus.exc_ill | ill_f3 | bus.exc_ebreak | bus.exc_ecall |
                     bus.exc_lmis | bus.exc_smis;

    always_comb begin
        exc_cause = 32'd6;
        if (bus.exc_imis)                exc_cause = 32'd0;
        else if (bus.exc_ill || ill_f3)  exc_cause = 32'd2;
        else if (bus.exc_ebreak)         exc_cause = 32'd3;
        else if (bus.exc_ecall)          exc_cause = 32'd11;
        else if (bus.exc_lmis)           exc_cause = 32'd4;
    end

`ifdef TRAP_CTRL_IRQ_EN
    // Level-sensitive: only taken on a non-CSR instruction, otherwise retried next instruction.
    assign irq_take = bus.irq_ext && !exc_any && !bus.is_mret && !bus.csr_op_valid;
`else
    logic unused_irq;
    assign unused_irq = bus.irq_ext;
    assign irq_take   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            tgt_ret_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tgt_ret_q <= tgt_ret_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        tgt_ret_d          = tgt_ret_q;
        bus.csr_addr       = bus.csr_addr_in;
        bus.csr_rd_data    = bus.csr_rdata;
        bus.csr_we         = 1'b0;
        bus.csr_wdata      = 32'd0;
        bus.trap_enter     = 1'b0;
        bus.trap_return    = 1'b0;
        bus.trap_pc        = 32'd0;
        bus.trap_cause     = 32'd0;
        bus.flush          = 1'b0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.busy           = 1'b0;
        // Outputs are held quiet while reset is asserted, even mid-sequence.
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.ex_valid) begin
                        if (exc_any || irq_take) begin
                            bus.trap_enter = 1'b1;
                            bus.trap_pc    = bus.ex_pc;
                            bus.trap_cause = exc_any ? exc_cause : IRQ_CAUSE;
                            bus.flush      = 1'b1;
                            state_d        = StFlush;
                            cnt_d          = 4'd0;
                            tgt_ret_d      = 1'b0;
                        end else if (bus.is_mret) begin
                            bus.trap_return = 1'b1;
                            bus.flush       = 1'b1;
                            state_d         = StFlush;
                            cnt_d           = 4'd0;
                            tgt_ret_d       = 1'b1;
                        end else if (bus.csr_op_valid) begin
                            unique case (bus.csr_funct3[1:0])
                                2'b01: begin
                                    bus.csr_we    = 1'b1;
                                    bus.csr_wdata = bus.csr_src;
                                end
                                2'b10: begin
                                    bus.csr_we    = !bus.csr_rs1_zero;
                                    bus.csr_wdata = bus.csr_rs1_zero ? 32'd0
                                                    : (bus.csr_rdata | bus.csr_src);
                                end
                                2'b11: begin
                                    bus.csr_we    = !bus.csr_rs1_zero;
                                    bus.csr_wdata = bus.csr_rs1_zero ? 32'd0
                                                    : (bus.csr_rdata & ~bus.csr_src);
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                StFlush: begin
                    bus.flush = 1'b1;
                    bus.stall = 1'b1;
                    bus.busy  = 1'b1;
                    if (cnt_q == CntLast) begin
                        state_d = StRedirect;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                StRedirect: begin
                    bus.flush          = 1'b1;
                    bus.stall          = 1'b1;
                    bus.busy           = 1'b1;
                    bus.redirect_valid = 1'b1;
                    bus.redirect_pc    = tgt_ret_q ? bus.mepc : (bus.mtvec & ~32'h3);
                    state_d            = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl (FLUSH_CYCLES=2); irq expectations follow
// whether TRAP_CTRL_IRQ_EN is defined for the build.
module tb_trap_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    trap_ctrl_if bus ();

    trap_ctrl #(.FLUSH_CYCLES(2), .IRQ_CAUSE(32'h8000000B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        bus.ex_valid     = 1'b0;
        bus.ex_pc        = 32'd0;
        bus.exc_imis     = 1'b0;
        bus.exc_ill      = 1'b0;
        bus.exc_ebreak   = 1'b0;
        bus.exc_ecall    = 1'b0;
        bus.exc_lmis     = 1'b0;
        bus.exc_smis     = 1'b0;
        bus.is_mret      = 1'b0;
        bus.irq_ext      = 1'b0;
        bus.csr_op_valid = 1'b0;
        bus.csr_funct3   = 3'b000;
        bus.csr_src      = 32'd0;
        bus.csr_rs1_zero = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_ex();
        bus.csr_addr_in = 12'h305;
        bus.csr_rdata   = 32'hA5A5_0001;
        bus.mtvec       = 32'h0000_0103;
        bus.mepc        = 32'h0000_0088;

        // Reset: control outputs quiet, CSR address/read data pass through
        rst = 1'b1;
        step();
        step();
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_flush", {31'd0, bus.flush}, 32'd0);
        chk("rst_trap_enter", {31'd0, bus.trap_enter}, 32'd0);
        chk("rst_csr_addr", {20'd0, bus.csr_addr}, 32'h305);
        chk("rst_csr_rd_data", bus.csr_rd_data, 32'hA5A5_0001);
        rst = 1'b0;
        step();

        // ECALL trap, then 2 flush cycles, then redirect to mtvec & ~3
        bus.ex_valid  = 1'b1;
        bus.ex_pc     = 32'h40;
        bus.exc_ecall = 1'b1;
        #1;
        chk("ecall_enter", {31'd0, bus.trap_enter}, 32'd1);
        chk("ecall_pc", bus.trap_pc, 32'h40);
        chk("ecall_cause", bus.trap_cause, 32'd11);
        chk("ecall_flush", {31'd0, bus.flush}, 32'd1);
        chk("ecall_stall", {31'd0, bus.stall}, 32'd0);
        step();
        #1;
        chk("fl1_stall", {31'd0, bus.stall}, 32'd1);
        chk("fl1_busy", {31'd0, bus.busy}, 32'd1);
        chk("fl1_no_enter", {31'd0, bus.trap_enter}, 32'd0);
        chk("fl1_cause_zero", bus.trap_cause, 32'd0);
        clear_ex();
        step();
        chk("fl2_stall", {31'd0, bus.stall}, 32'd1);
        chk("fl2_no_redir", {31'd0, bus.redirect_valid}, 32'd0);
        step();
        chk("redir_valid", {31'd0, bus.redirect_valid}, 32'd1);
        chk("redir_pc", bus.redirect_pc, 32'h100);
        step();
        chk("ecall_idle", {31'd0, bus.busy}, 32'd0);
        chk("ecall_redir_off", {31'd0, bus.redirect_valid}, 32'd0);

        // Priority: ill over lmis, trap suppresses a simultaneous CSRRW
        bus.ex_valid     = 1'b1;
        bus.ex_pc        = 32'h44;
        bus.exc_ill      = 1'b1;
        bus.exc_lmis     = 1'b1;
        bus.csr_op_valid = 1'b1;
        bus.csr_funct3   = 3'b001;
        bus.csr_src      = 32'h5;
        #1;
        chk("prio_cause", bus.trap_cause, 32'd2);
        chk("prio_we", {31'd0, bus.csr_we}, 32'd0);
        chk("prio_wdata", bus.csr_wdata, 32'd0);
        bus.exc_imis = 1'b1;
        #1;
        chk("prio_imis", bus.trap_cause, 32'd0);
        clear_ex();
        for (int i = 0; i < 4; i++) step();
        chk("prio_idle", {31'd0, bus.busy}, 32'd0);

        // CSRRS with and without a write
        bus.ex_valid     = 1'b1;
        bus.csr_op_valid = 1'b1;
        bus.csr_funct3   = 3'b010;
        bus.csr_addr_in  = 12'h300;
        bus.csr_rdata    = 32'h0F;
        bus.csr_src      = 32'hF0;
        #1;
        chk("rs_wdata", bus.csr_wdata, 32'hFF);
        chk("rs_we", {31'd0, bus.csr_we}, 32'd1);
        chk("rs_rd_data", bus.csr_rd_data, 32'h0F);
        chk("rs_addr", {20'd0, bus.csr_addr}, 32'h300);
        chk("rs_no_trap", {31'd0, bus.trap_enter}, 32'd0);
        bus.csr_rs1_zero = 1'b1;
        #1;
        chk("rs_zero_we", {31'd0, bus.csr_we}, 32'd0);
        // CSRRC, CSRRWI (writes even with zero field)
        bus.csr_rs1_zero = 1'b0;
        bus.csr_funct3   = 3'b011;
        bus.csr_rdata    = 32'hFF;
        bus.csr_src      = 32'h0F;
        #1;
        chk("rc_wdata", bus.csr_wdata, 32'hF0);
        chk("rc_we", {31'd0, bus.csr_we}, 32'd1);
        bus.csr_funct3   = 3'b101;
        bus.csr_src      = 32'h1234;
        bus.csr_rs1_zero = 1'b1;
        #1;
        chk("rwi_wdata", bus.csr_wdata, 32'h1234);
        chk("rwi_we", {31'd0, bus.csr_we}, 32'd1);
        step();
        chk("csr_no_busy", {31'd0, bus.busy}, 32'd0);

        // Illegal funct3 100
        bus.csr_funct3   = 3'b100;
        bus.csr_rs1_zero = 1'b0;
        #1;
        chk("f3_ill_enter", {31'd0, bus.trap_enter}, 32'd1);
        chk("f3_ill_cause", bus.trap_cause, 32'd2);
        chk("f3_ill_we", {31'd0, bus.csr_we}, 32'd0);
        clear_ex();
        for (int i = 0; i < 4; i++) step();

        // MRET to mepc
        bus.ex_valid = 1'b1;
        bus.is_mret  = 1'b1;
        #1;
        chk("mret_ret", {31'd0, bus.trap_return}, 32'd1);
        chk("mret_flush", {31'd0, bus.flush}, 32'd1);
        chk("mret_no_enter", {31'd0, bus.trap_enter}, 32'd0);
        step();
        chk("mret_fl_ret_off", {31'd0, bus.trap_return}, 32'd0);
        clear_ex();
        step();
        step();
        chk("mret_redir_valid", {31'd0, bus.redirect_valid}, 32'd1);
        chk("mret_redir_pc", bus.redirect_pc, 32'h88);
        step();

        // Reset during FLUSH abandons the sequence
        bus.ex_valid = 1'b1;
        bus.is_mret  = 1'b1;
        step();
        clear_ex();
        chk("abort_busy_pre", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_redir", {31'd0, bus.redirect_valid}, 32'd0);
        step();
        chk("abort_redir2", {31'd0, bus.redirect_valid}, 32'd0);
        step();
        chk("abort_redir3", {31'd0, bus.redirect_valid}, 32'd0);

        // External interrupt: deferred over a CSR op
        bus.ex_valid     = 1'b1;
        bus.ex_pc        = 32'h20;
        bus.irq_ext      = 1'b1;
        bus.csr_op_valid = 1'b1;
        bus.csr_funct3   = 3'b001;
        bus.csr_src      = 32'h7;
        #1;
        chk("irq_csr_no_trap", {31'd0, bus.trap_enter}, 32'd0);
        chk("irq_csr_we", {31'd0, bus.csr_we}, 32'd1);
        step();
        bus.csr_op_valid = 1'b0;
        #1;
`ifdef TRAP_CTRL_IRQ_EN
        chk("irq_enter", {31'd0, bus.trap_enter}, 32'd1);
        chk("irq_cause", bus.trap_cause, 32'h8000000B);
        chk("irq_pc", bus.trap_pc, 32'h20);
`else
        chk("irq_off_enter", {31'd0, bus.trap_enter}, 32'd0);
        chk("irq_off_cause", bus.trap_cause, 32'd0);
        chk("irq_off_flush", {31'd0, bus.flush}, 32'd0);
`endif
        clear_ex();
        for (int i = 0; i < 4; i++) step();
        chk("end_idle", {31'd0, bus.busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
